// File: rtl/lowampa_power_trigger.sv
// lowampa_power_trigger
// Sliding-window energy detector behind the low-amplitude matched filter.
// Each clock, NSAMPS signed samples are squared and summed. A window of the
// last WINDOW_CLKS sums is kept in the accumulator. The accumulator is
// compared against a runtime threshold to produce a one-cycle trigger,
// followed by a fixed holdoff.
// Optional build macro: LOWAMPA_TRIG_SCALER_EN adds a saturating trigger counter on scaler_o.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | pipeline/window priming after reset, trigger suppressed
// ST_ARM  | armed, trigger fires when power > threshold
// ST_HOLD | holdoff after a trigger, HOLDOFF_CLKS clocks
module lowampa_power_trigger #(
    parameter int          NBITS          = 12,
    parameter int          NSAMPS         = 4,
    parameter int          WINDOW_CLKS    = 8,
    parameter int          HOLDOFF_CLKS   = 32,
    parameter int unsigned THRESH_DEFAULT = 32'd1 << 20,
    parameter int          ACC_W          = 2*NBITS + $clog2(NSAMPS) + $clog2(WINDOW_CLKS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NBITS*NSAMPS-1:0] dat_i,
    input  logic [ACC_W-1:0]        thresh_i,
    input  logic                    thresh_wr_i,
    output logic                    thresh_ack_o,
    output logic [ACC_W-1:0]        power_o,
    output logic                    trig_o,
    output logic                    armed_o,
    output logic [15:0]             scaler_o,
    input  logic                    scaler_clr_i
);

    localparam int SQ_W      = 2*NBITS;
    localparam int S_W       = SQ_W + $clog2(NSAMPS);
    localparam int FILL_CLKS = WINDOW_CLKS + 3;
    localparam int CNT_MAX   = (FILL_CLKS > HOLDOFF_CLKS) ? FILL_CLKS : HOLDOFF_CLKS;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_ARM  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [NBITS*NSAMPS-1:0] dat_q;
    logic [SQ_W-1:0]         sq_d [NSAMPS];
    logic [SQ_W-1:0]         sq_q [NSAMPS];
    logic [S_W-1:0]          s_d;
    logic [S_W-1:0]          s_q;
    logic [S_W-1:0]          dly_q [WINDOW_CLKS];
    logic [ACC_W-1:0]        acc_d;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        thresh_q;
    logic                    ack_q;
    state_t                  state_d, state_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    trig_d, trig_q;

    // Squaring is done at 2*NBITS signed width so (-2^(NBITS-1))^2 is exact.
    for (genvar k = 0; k < NSAMPS; k++) begin : g_sq
        logic signed [NBITS-1:0] samp;
        logic signed [SQ_W-1:0]  samp_ext;
        logic signed [SQ_W-1:0]  prod;
        assign samp     = dat_q[NBITS*k +: NBITS];
        assign samp_ext = SQ_W'(samp);
        assign prod     = samp_ext * samp_ext;
        assign sq_d[k]  = unsigned'(prod);
    end

    // Sum of the per-sample squares for this clock.
    always_comb begin
        s_d = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            s_d = s_d + S_W'(sq_q[k]);
        end
    end

    // The oldest entry in the delay line always went into acc earlier, so
    // the subtraction cannot underflow and the sum stays within ACC_W bits.
    assign acc_d = acc_q + ACC_W'(s_q) - ACC_W'(dly_q[WINDOW_CLKS-1]);

    // Datapath pipeline: input, squares, per-clock sum, window accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_q <= '0;
            for (int k = 0; k < NSAMPS; k++) sq_q[k] <= '0;
            s_q   <= '0;
            for (int i = 0; i < WINDOW_CLKS; i++) dly_q[i] <= '0;
            acc_q <= '0;
        end else begin
            dat_q <= dat_i;
            for (int k = 0; k < NSAMPS; k++) sq_q[k] <= sq_d[k];
            s_q      <= s_d;
            dly_q[0] <= s_q;
            for (int i = 1; i < WINDOW_CLKS; i++) dly_q[i] <= dly_q[i-1];
            acc_q    <= acc_d;
        end
    end

    // Threshold register and its write acknowledge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            thresh_q <= ACC_W'(THRESH_DEFAULT);
            ack_q    <= 1'b0;
        end else begin
            if (thresh_wr_i) thresh_q <= thresh_i;
            ack_q <= thresh_wr_i;
        end
    end

    // Trigger FSM state register with its shared down-counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_FILL;
            cnt_q   <= CNT_W'(FILL_CLKS - 1);
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
        end
    end

    // Next-state logic; the compare sees the threshold before any same-cycle write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                if (cnt_q == '0) state_d = ST_ARM;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ARM: begin
                if (acc_q > thresh_q) begin
                    trig_d  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLDOFF_CLKS - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) state_d = ST_ARM;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = CNT_W'(FILL_CLKS - 1);
            end
        endcase
    end

`ifdef LOWAMPA_TRIG_SCALER_EN
    logic [15:0] scaler_q;

    // Saturating trigger counter; a clear coinciding with a trigger leaves 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scaler_q <= '0;
        end else if (scaler_clr_i) begin
            scaler_q <= trig_q ? 16'd1 : 16'd0;
        end else if (trig_q && (scaler_q != 16'hFFFF)) begin
            scaler_q <= scaler_q + 16'd1;
        end
    end

    assign scaler_o = scaler_q;
`else
    logic unused_scaler_clr;
    assign unused_scaler_clr = scaler_clr_i;
    assign scaler_o          = '0;
`endif

    assign thresh_ack_o = ack_q;
    assign power_o      = acc_q;
    assign trig_o       = trig_q;
    assign armed_o      = (state_q == ST_ARM);

endmodule
